ex_stage_md: RTL
================

// Module: ex_stage_md
// PURPOSE
//  Execute stage, next generation: ALU/CMP single-cycle path plus an RV32M multiply/divide unit.
//  Sits between the ID/EX and EX/MEM pipeline registers.
//  MUL ops run on a fixed-latency pipelined multiplier; DIV/REM ops run on an iterative divider.
//  While a multi-cycle op is in flight, busy stalls the pipeline.
// PARAMETERS
//  XLEN        32  datapath width (rs values, imm, alu_out)
//  MUL_STAGES  2   multiplier register stages (>=1)
//  DIV_BITS    1   quotient bits retired per divider cycle; must divide XLEN (1,2,4)
// PORTS
//  clk        in   1               clock
//  rst_n      in   1               asynchronous reset, active-low
//  move       in   1               pipeline advance from hazard unit (already gated with !busy)
//  flush      in   1               kill instruction in EX (branch mispredict / trap)
//  rs1_v      in   XLEN            forwarded rs1 value
//  rs2_v      in   XLEN            forwarded rs2 value
//  id_ex_reg  in   id_ex_stage_reg_t   ID/EX register; ex_ctrl_s carries md_en, mdop
//  ex_mem_reg out  ex_mem_stage_reg_t  EX/MEM register next-state
//  busy       out  1               EX holds an incomplete MD op; hazard unit must stall
// BEHAVIOUR
//  - Non-MD ops (md_en=0): ALU/CMP operand muxing is combinational; busy=0; zero extra latency.
//  - EX/MEM valid: ex_mem_reg.valid_s = move & id_ex_reg.valid_s & !busy & !flush.
//  - FSM states: IDLE, MUL, DIV, FIX, DONE.
//    Reset: state=IDLE; cnt, acc, and result regs = 0; busy=0.
//  - start = IDLE & valid_s & md_en & !flush.
//  - busy = start | (state in {MUL,DIV,FIX}).
//    Combinational; asserted in the start cycle itself.
//  - IDLE->MUL on start with mdop in {MUL,MULH,MULHSU,MULHU}.
//    MUL lasts exactly MUL_STAGES cycles, then ->DONE.
//  - IDLE->DIV on start with mdop in {DIV,DIVU,REM,REMU}, normal operands.
//    Operands are made absolute when signed. DIV lasts XLEN/DIV_BITS cycles (cnt counts down).
//    Then ->FIX (1 cycle: apply quotient/remainder sign), then ->DONE.
//  - Special divide cases skip DIV/FIX and go IDLE->DONE directly (busy only in the start cycle):
//    - divisor=0: quotient = all-ones; remainder = rs1_v.
//    - signed overflow (rs1=0x8000_0000, rs2=-1): quotient = rs1_v; remainder = 0.
//  - Busy cycles: MUL = 1+MUL_STAGES; DIV = 2+XLEN/DIV_BITS; special = 1.
//  - DONE: result reg drives alu_out_s, busy=0. DONE->IDLE when move=1.
//    The same instruction is never restarted while in DONE.
//  - Result selection:
//    - MUL: low XLEN bits. MULH/MULHSU/MULHU: high XLEN bits of the 2*XLEN product.
//    - Signedness per RV32M.
//  - Operands are latched on start. rs1_v/rs2_v changes while busy are ignored.
//  - flush in any state: ->IDLE next edge, busy=0 that cycle, result discarded.
//    flush has priority over start and move.
//  - Back-to-back MD ops: second op starts the cycle after the DONE->IDLE move.
//  - rst_n deassert mid-op: FSM returns to IDLE immediately (async). No partial result escapes.
//  - All other ex_mem_reg fields pass through from id_ex_reg as in the single-cycle path.
// STRUCTURE
//  - rv32i_types additions:
//    - mdop_t enum (8 RV32M ops)
//    - md_state_t enum (IDLE/MUL/DIV/FIX/DONE)
//    - md_en and mdop fields in ex_ctrl_t
//  - Sub-module ex_divider (XLEN, DIV_BITS): iterative restoring divider.
//    start/done handshake; unsigned q/r outputs.
//  - Multiplier: inline (XLEN+1)x(XLEN+1) signed multiply + MUL_STAGES shift-register, with a valid bit.
// TESTING
//  1. MUL 7*-3, MUL_STAGES=2 -> busy 3 cycles; alu_out=0xFFFF_FFEB; valid_s only after DONE & move.
//  2. MULHU 0xFFFF_FFFF*0xFFFF_FFFF -> 0xFFFF_FFFE; MULH same operands -> 0x0000_0000.
//  3. DIV -7/2, REM -7/2 -> 0xFFFF_FFFD and 0xFFFF_FFFF; busy exactly 34 cycles each (DIV_BITS=1).
//  4. DIVU 5/0 -> 0xFFFF_FFFF, REMU 5/0 -> 5; DIV 0x8000_0000/-1 -> 0x8000_0000; busy 1 cycle each.
//  5. flush at cycle 10 of a DIV -> busy=0 that cycle, IDLE next; following ADD 1+2 -> 3 with no stall.
//  6. rst_n low mid-MUL, then ADD/DIV back-to-back -> outputs reset; ADD zero-stall; DIV starts next cycle.

Source files
------------

// File: rtl/ex_stage_md_pkg.sv
// Shared types for the execute stage: ALU/compare opcodes, RV32M opcodes,
// the multiply/divide FSM states and the ID/EX and EX/MEM register layouts.
package ex_stage_md_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [2:0] {
        CMP_EQ, CMP_NE, CMP_LT, CMP_GE, CMP_LTU, CMP_GEU
    } cmp_op_t;

    // Encoded in RV32M funct3 order: bit 2 selects divide, bit 1 selects remainder.
    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
        MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } mdop_t;

    typedef enum logic [2:0] {
        MD_IDLE, MD_MUL_ST, MD_DIV_ST, MD_FIX, MD_DONE
    } md_state_t;

    typedef struct packed {
        alu_op_t alu_op;
        cmp_op_t cmp_op;
        logic    alu_a_pc;
        logic    alu_b_imm;
        logic    md_en;
        mdop_t   mdop;
    } ex_ctrl_t;

    typedef struct packed {
        logic            valid_s;
        logic [XLEN-1:0] pc_s;
        logic [XLEN-1:0] imm_s;
        logic [4:0]      rd_s;
        logic            rf_we_s;
        logic            mem_rd_s;
        logic            mem_wr_s;
        ex_ctrl_t        ex_ctrl_s;
    } id_ex_stage_reg_t;

    typedef struct packed {
        logic            valid_s;
        logic [XLEN-1:0] pc_s;
        logic [XLEN-1:0] alu_out_s;
        logic [XLEN-1:0] store_data_s;
        logic            br_en_s;
        logic [4:0]      rd_s;
        logic            rf_we_s;
        logic            mem_rd_s;
        logic            mem_wr_s;
    } ex_mem_stage_reg_t;

    function automatic logic [XLEN-1:0] alu_eval(input alu_op_t op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [$clog2(XLEN)-1:0] shamt;
        shamt = b[$clog2(XLEN)-1:0];
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << shamt;
            ALU_SLT:  return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: return {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> shamt;
            ALU_SRA:  return $signed(a) >>> shamt;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return '0;
        endcase
    endfunction

    function automatic logic cmp_eval(input cmp_op_t op,
                                      input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
        case (op)
            CMP_EQ:  return a == b;
            CMP_NE:  return a != b;
            CMP_LT:  return $signed(a) < $signed(b);
            CMP_GE:  return $signed(a) >= $signed(b);
            CMP_LTU: return a < b;
            CMP_GEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_stage_md_if.sv
// Pipeline-side bundle of the execute stage: ID/EX inputs, EX/MEM next-state and stall.
interface ex_stage_md_if;
    import ex_stage_md_pkg::*;

    // Handshake: id_ex_reg is offered when id_ex_reg.valid_s=1 and is consumed on a
    // rising edge where move=1 (move already includes !busy). busy=1 means EX is not
    // ready; ex_mem_reg.valid_s marks the cycle the instruction leaves EX. flush
    // kills the EX instruction that cycle regardless of move.
    logic              move;
    logic              flush;
    logic [XLEN-1:0]   rs1_v;
    logic [XLEN-1:0]   rs2_v;
    id_ex_stage_reg_t  id_ex_reg;
    ex_mem_stage_reg_t ex_mem_reg;
    logic              busy;

    modport master (
        output move, flush, rs1_v, rs2_v, id_ex_reg,
        input  ex_mem_reg, busy
    );

    modport slave (
        input  move, flush, rs1_v, rs2_v, id_ex_reg,
        output ex_mem_reg, busy
    );

endinterface

// File: rtl/ex_stage_md_divider.sv
// Iterative restoring divider on unsigned operands; retires DIV_BITS quotient bits
// per cycle. start_i loads the operands, done_o flags the cycle of the final step.
module ex_stage_md_divider #(
    parameter int XLEN     = 32,
    parameter int DIV_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o
);

    localparam int STEPS = XLEN / DIV_BITS;
    localparam int CW    = $clog2(STEPS + 1);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   rem_sh;

    // The quotient register doubles as the dividend shifter: its MSB feeds the
    // partial remainder while new quotient bits enter at the LSB.
    always_comb begin
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        rem_sh = '0;
        if (cnt_q != '0) begin
            for (int i = 0; i < DIV_BITS; i++) begin
                rem_sh = {rem_d, quo_d[XLEN-1]};
                if (rem_sh >= {1'b0, dvs_q}) begin
                    rem_d = rem_sh[XLEN-1:0] - dvs_q;
                    quo_d = {quo_d[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[XLEN-1:0];
                    quo_d = {quo_d[XLEN-2:0], 1'b0};
                end
            end
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (start_i) begin
            cnt_q <= CW'(STEPS);
            quo_q <= dividend_i;
            rem_q <= '0;
            dvs_q <= divisor_i;
        end else begin
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
        end
    end

    assign done_o = (cnt_q == CW'(1));
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: single-cycle ALU/compare path plus an RV32M unit with a pipelined
// multiplier and an iterative divider; busy stalls the pipeline while an MD op runs.
module ex_stage_md
    import ex_stage_md_pkg::*;
#(
    parameter int MUL_STAGES = 2,
    parameter int DIV_BITS   = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    ex_stage_md_if.slave ex_if,
    output md_state_t dbg_state_o
);

    id_ex_stage_reg_t  id_ex;
    ex_mem_stage_reg_t ex_mem;
    logic [XLEN-1:0]   rs1, rs2;
    logic              flush, move;

    assign id_ex = ex_if.id_ex_reg;
    assign rs1   = ex_if.rs1_v;
    assign rs2   = ex_if.rs2_v;
    assign flush = ex_if.flush;
    assign move  = ex_if.move;

    md_state_t       state_q, state_d;
    mdop_t           mdop_q;
    logic            q_neg_q, r_neg_q;
    logic [XLEN-1:0] result_q;
    logic            start, in_flight, busy;

    logic            is_mul_op, div_signed, div_special;
    logic [XLEN-1:0] special_val;
    logic [XLEN-1:0] div_a, div_b;
    logic            div_start, div_done;
    logic [XLEN-1:0] div_quo, div_rem, fix_res;

    logic                   mul_a_sgn, mul_b_sgn;
    logic signed [XLEN:0]   mul_a, mul_b;
    logic [2*XLEN-1:0]      mul_prod;
    logic [2*XLEN-1:0]      mul_pipe_q [MUL_STAGES];
    logic [MUL_STAGES-1:0]  mul_vld_q;
    logic [XLEN-1:0]        mul_res;

    assign start     = (state_q == MD_IDLE) && id_ex.valid_s && id_ex.ex_ctrl_s.md_en && !flush;
    assign in_flight = (state_q == MD_MUL_ST) || (state_q == MD_DIV_ST) || (state_q == MD_FIX);
    assign busy      = !flush && (start || in_flight);

    // Operand decode for the op being started.
    assign is_mul_op  = !id_ex.ex_ctrl_s.mdop[2];
    assign div_signed = !id_ex.ex_ctrl_s.mdop[0];
    assign mul_a_sgn  = (id_ex.ex_ctrl_s.mdop == MD_MULH) || (id_ex.ex_ctrl_s.mdop == MD_MULHSU);
    assign mul_b_sgn  = (id_ex.ex_ctrl_s.mdop == MD_MULH);

    // Divide-by-zero and INT_MIN/-1 finish in the start cycle with RV32M-defined results.
    always_comb begin
        div_special = 1'b0;
        special_val = '0;
        if (!is_mul_op) begin
            if (rs2 == '0) begin
                div_special = 1'b1;
                special_val = id_ex.ex_ctrl_s.mdop[1] ? rs1 : '1;
            end else if (div_signed && rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1) begin
                div_special = 1'b1;
                special_val = id_ex.ex_ctrl_s.mdop[1] ? '0 : rs1;
            end
        end
    end

    assign mul_a    = {mul_a_sgn & rs1[XLEN-1], rs1};
    assign mul_b    = {mul_b_sgn & rs2[XLEN-1], rs2};
    assign mul_prod = (2*XLEN)'(mul_a) * (2*XLEN)'(mul_b);
    assign mul_res  = (mdop_q == MD_MUL) ? mul_pipe_q[MUL_STAGES-1][XLEN-1:0]
                                         : mul_pipe_q[MUL_STAGES-1][2*XLEN-1:XLEN];

    assign div_a     = (div_signed && rs1[XLEN-1]) ? -rs1 : rs1;
    assign div_b     = (div_signed && rs2[XLEN-1]) ? -rs2 : rs2;
    assign div_start = start && !is_mul_op && !div_special;

    ex_stage_md_divider #(
        .XLEN     (XLEN),
        .DIV_BITS (DIV_BITS)
    ) u_ex_divider (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (flush),
        .start_i    (div_start),
        .dividend_i (div_a),
        .divisor_i  (div_b),
        .done_o     (div_done),
        .quo_o      (div_quo),
        .rem_o      (div_rem)
    );

    assign fix_res = mdop_q[1] ? (r_neg_q ? -div_rem : div_rem)
                               : (q_neg_q ? -div_quo : div_quo);

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = MD_IDLE;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        if (is_mul_op)        state_d = MD_MUL_ST;
                        else if (div_special) state_d = MD_DONE;
                        else                  state_d = MD_DIV_ST;
                    end
                end
                MD_MUL_ST: if (mul_vld_q[MUL_STAGES-1]) state_d = MD_DONE;
                MD_DIV_ST: if (div_done) state_d = MD_FIX;
                MD_FIX:    state_d = MD_DONE;
                MD_DONE:   if (move) state_d = MD_IDLE;
                default:   state_d = MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MD_IDLE;
            mdop_q    <= MD_MUL;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_q  <= '0;
            mul_vld_q <= '0;
            for (int i = 0; i < MUL_STAGES; i++) mul_pipe_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                mul_vld_q <= '0;
                result_q  <= '0;
            end else begin
                for (int i = MUL_STAGES-1; i > 0; i--) begin
                    mul_vld_q[i]  <= mul_vld_q[i-1];
                    mul_pipe_q[i] <= mul_pipe_q[i-1];
                end
                mul_vld_q[0] <= start && is_mul_op;
                if (start && is_mul_op) mul_pipe_q[0] <= mul_prod;
                if (start) begin
                    mdop_q   <= id_ex.ex_ctrl_s.mdop;
                    q_neg_q  <= div_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
                    r_neg_q  <= div_signed && rs1[XLEN-1];
                    result_q <= div_special ? special_val : '0;
                end else if (state_q == MD_MUL_ST && mul_vld_q[MUL_STAGES-1]) begin
                    result_q <= mul_res;
                end else if (state_q == MD_FIX) begin
                    result_q <= fix_res;
                end
            end
        end
    end

    always_comb begin
        ex_mem              = '0;
        ex_mem.valid_s      = move && id_ex.valid_s && !busy && !flush;
        ex_mem.pc_s         = id_ex.pc_s;
        ex_mem.store_data_s = rs2;
        ex_mem.br_en_s      = cmp_eval(id_ex.ex_ctrl_s.cmp_op, rs1, rs2);
        ex_mem.rd_s         = id_ex.rd_s;
        ex_mem.rf_we_s      = id_ex.rf_we_s;
        ex_mem.mem_rd_s     = id_ex.mem_rd_s;
        ex_mem.mem_wr_s     = id_ex.mem_wr_s;
        if (id_ex.ex_ctrl_s.md_en) begin
            ex_mem.alu_out_s = (state_q == MD_DONE) ? result_q : '0;
        end else begin
            ex_mem.alu_out_s = alu_eval(id_ex.ex_ctrl_s.alu_op,
                                        id_ex.ex_ctrl_s.alu_a_pc  ? id_ex.pc_s  : rs1,
                                        id_ex.ex_ctrl_s.alu_b_imm ? id_ex.imm_s : rs2);
        end
    end

    assign ex_if.ex_mem_reg = ex_mem;
    assign ex_if.busy       = busy;
    assign dbg_state_o      = state_q;

endmodule
